// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller and its IF/ID consumer.
package if_fetch_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    SEL_PASS   = 2'b00,
    SEL_REPLAY = 2'b01,
    SEL_FLUSH  = 2'b10
  } instr_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC, keeps at most one instruction-memory
// grant in flight, and feeds pc/instr/instr_sel/loadUse into the IF/ID register.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_loadUse,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc_IF,
  output logic [31:0] instr_IF,
  output logic [1:0]  instr_sel,
  output logic        loadUse
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic         kill_q, kill_d;
  logic         skid_v_q, skid_v_d;
  logic [31:0]  skid_data_q, skid_data_d;

  logic active, flush, stall, pend, rsp, live, fire;

  // A grant is pending while in WAIT, or while a killed response is still due.
  always_comb begin
    active  = (state_q != IDLE);
    flush   = active & redirect;
    stall   = active & hazard_loadUse & ~redirect;
    pend    = (state_q == WAIT) | kill_q;
    rsp     = im_rvalid & pend;
    live    = rsp & ~kill_q;
    im_req  = active & ~stall & (~pend | rsp);
    im_addr = pc_q;
    fire    = im_req & im_gnt;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    kill_d      = kill_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    case (state_q)
      IDLE: state_d = REQ;
      default: begin
        if (fire) begin
          state_d  = WAIT;
          rsp_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
        end else if (rsp) begin
          state_d = REQ;
        end
        if (fire | rsp) begin
          kill_d = 1'b0;
        end
        // Redirect drops whatever is in flight, including a grant taken this cycle.
        if (flush) begin
          state_d  = REQ;
          pc_d     = word_align(redirect_pc);
          kill_d   = fire | (pend & ~rsp);
          skid_v_d = 1'b0;
        end else if (stall) begin
          if (live) begin
            skid_v_d    = 1'b1;
            skid_data_d = im_rdata;
          end
        end else begin
          skid_v_d = 1'b0;
        end
      end
    endcase
  end

  // A skid entry can never meet a fresh response: no grant is issued while stalled.
  always_comb begin
    instr_sel = SEL_FLUSH;
    loadUse   = 1'b0;
    pc_IF     = rsp_pc_q;
    instr_IF  = '0;
    if (!flush) begin
      if (stall) begin
        instr_sel = SEL_REPLAY;
        loadUse   = 1'b1;
      end else if (skid_v_q) begin
        instr_sel = SEL_PASS;
        instr_IF  = skid_data_q;
      end else if (live) begin
        instr_sel = SEL_PASS;
        instr_IF  = im_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      kill_q   <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      kill_q   <= kill_d;
      skid_v_q <= skid_v_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl: a random-latency memory, random stalls and
// redirects, and a program-order scoreboard of the instructions that must reach IF/ID.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          NCYC   = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_loadUse, redirect, im_gnt, im_rvalid;
  logic [31:0] redirect_pc, im_rdata;
  logic        im_req, loadUse;
  logic [31:0] im_addr, pc_IF, instr_IF;
  logic [1:0]  instr_sel;

  int          checks = 0;
  int          errors = 0;
  int          n_present = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl_fetch_pc;
  logic [31:0] mon_e;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .hazard_loadUse(hazard_loadUse), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata), .pc_IF(pc_IF), .instr_IF(instr_IF),
    .instr_sel(instr_sel), .loadUse(loadUse)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ NOP_INSTR;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_im_req"},    32'(im_req),    32'd0);
    chk({tag, "_im_addr"},   im_addr,        RST_PC);
    chk({tag, "_pc_IF"},     pc_IF,          RST_PC);
    chk({tag, "_instr_IF"},  instr_IF,       32'd0);
    chk({tag, "_instr_sel"}, 32'(instr_sel), 32'(SEL_FLUSH));
    chk({tag, "_loadUse"},   32'(loadUse),   32'd0);
  endtask

  // Monitor: checks per-cycle control outputs and pops the scoreboard on each pass.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (redirect) begin
        chk("redirect_sel", 32'(instr_sel), 32'(SEL_FLUSH));
        chk("redirect_lu",  32'(loadUse),   32'd0);
      end else if (hazard_loadUse) begin
        chk("stall_sel", 32'(instr_sel), 32'(SEL_REPLAY));
        chk("stall_lu",  32'(loadUse),   32'd1);
        chk("stall_req", 32'(im_req),    32'd0);
      end else begin
        chk("lu_low", 32'(loadUse), 32'd0);
        if (instr_sel == SEL_PASS) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_present: pc_IF %h instr %h with nothing expected at %0t",
                     pc_IF, instr_IF, $time);
          end else begin
            mon_e = exp_q.pop_front();
            chk("pc_IF", pc_IF, mon_e);
            chk("instr_IF", instr_IF, mem_word(mon_e));
            n_present++;
          end
        end else begin
          chk("sel_bubble", 32'(instr_sel), 32'(SEL_FLUSH));
        end
      end
    end
  end

  // Driver, memory responder and reference model.
  initial begin
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          stale, rel, did_rst, quiet, drain, fire;
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
    stale = 1'b0; rel = 1'b0; did_rst = 1'b0;

    rst = 1'b1; hazard_loadUse = 1'b0; redirect = 1'b0; redirect_pc = '0;
    im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
    mdl_fetch_pc = RST_PC;

    repeat (2) @(negedge clk);
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("idle_req", 32'(im_req), 32'd0);
    chk("idle_sel", 32'(instr_sel), 32'(SEL_FLUSH));
    mon_en = 1'b1;

    for (int i = 0; i < NCYC + 8; i++) begin
      @(negedge clk);
      if (rel) rst = 1'b0;
      drain = (i >= NCYC);
      quiet = (i < 20) || rel || drain;

      im_rvalid = 1'b0;
      im_rdata  = $urandom;
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          im_rvalid = 1'b1;
          im_rdata  = mem_word(mem_addr);
        end
      end
      hazard_loadUse = !quiet && ($urandom_range(0, 9) == 0);
      redirect       = !quiet && ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      im_gnt         = !stale && !drain && ((i < 20) || ($urandom_range(0, 3) != 0));
      rel = 1'b0;

      #1;
      fire = im_req && im_gnt;
      if (fire) chk("one_outstanding", 32'(mem_pend && !im_rvalid), 32'd0);
      if (im_rvalid) begin
        mem_pend = 1'b0;
        stale    = 1'b0;
      end
      if (fire) begin
        mem_pend = 1'b1;
        mem_addr = im_addr;
        mem_cnt  = $urandom_range(1, 3);
      end

      if (redirect) begin
        exp_q.delete();
        mdl_fetch_pc = {redirect_pc[31:2], 2'b00};
      end else if (fire) begin
        chk("im_addr", im_addr, mdl_fetch_pc);
        exp_q.push_back(mdl_fetch_pc);
        mdl_fetch_pc = mdl_fetch_pc + 32'd4;
      end

      // Asynchronous reset while a live fetch is still in flight.
      if (!did_rst && i >= NCYC / 2 && mem_pend && !fire && !im_rvalid && !redirect &&
          exp_q.size() > 0) begin
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        mdl_fetch_pc = RST_PC;
        stale   = 1'b1;
        rel     = 1'b1;
        did_rst = 1'b1;
      end
    end

    @(negedge clk);
    #3;
    mon_en = 1'b0;
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("presented_enough", 32'(n_present > 200), 32'd1);
    chk("midrst_done", 32'(did_rst), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
